control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit for the single-bus CPU datapath.
- Steps the datapath through fetch (T0–T2) and opcode-specific execute steps (T3–T7).
- Drives every register in/out enable, the ALU opcode, IncPC, Read/Write and the C-immediate out enable.
- Sits beside the datapath. Takes IR contents back from it and a ready handshake from memory.

Parameters:
MEM_TIMEOUT, 255, max cycles to wait for mem_ready before entering FAULT (8-bit counter)

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous, active-low reset
run  in  1  level; start/continue execution
ir  in  32  IR register contents: op [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0]
mem_ready  in  1  memory access complete this cycle
Rin  out  16  one-hot R0in..R15in
Rout  out  16  one-hot R0out..R15out
HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin  out  1 each  register load enables
HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout  out  1 each  bus drive enables
IncPC, Read, Write  out  1 each  PC increment; memory read / MDR source select; memory write
opcode  out  5  ALU operation
halted  out  1  high in HALT state
fault  out  1  high in FAULT state
illegal  out  1  one-cycle pulse on an undefined opcode
state_out  out  4  current state, for debug

Behaviour:
- Moore FSM. States: IDLE, T0..T7, HALT, FAULT.
- All outputs decode combinationally from the state register and ir. IDLE decodes to all zeros.
- clear low (asynchronous, including mid-instruction): state←IDLE, timeout counter←0.
  - All outputs are 0 while clear is low and on release.
- At most one of Rout/HIout/LOout/Zhighout/Zlowout/PCout/MDRout/Cout is high in any state.
- IDLE: go to T0 when run=1.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read. MDRin only in the cycle mem_ready=1; stay in T1 until then.
  - T2: MDRout, IRin.
- Execute (opcode = ADD=3 for address/immediate steps unless stated):
  - ALU R-type (add 3, sub 4, and 5, or 6, shr 7, shra 8, shl 9, ror 10, rol 11):
    - T3 Rout[Rb], Yin
    - T4 Rout[Rc], opcode=ir[31:27], Zin
    - T5 Zlowout, Rin[Ra]
  - Immediate (addi 12, andi 13, ori 14; ldi 1 uses ADD):
    - T3 Rout[Rb], Yin
    - T4 Cout, opcode=3/5/6, Zin
    - T5 Zlowout, Rin[Ra]
  - ld 0:
    - T3–T4 as ldi
    - T5 Zlowout, MARin
    - T6 Read, MDRin only when mem_ready; stay in T6 until then
    - T7 MDRout, Rin[Ra]
  - st 2:
    - T3–T4 as ldi
    - T5 Zlowout, MARin
    - T6 Rout[Ra], MDRin, Read=0
    - T7 Write held until mem_ready
  - mul 15 / div 16:
    - T3 Rout[Ra], Yin
    - T4 Rout[Rb], opcode, Zin
    - T5 Zlowout, LOin
    - T6 Zhighout, HIin
  - neg 17 / not 18:
    - T3 Rout[Rb], opcode, Zin
    - T4 Zlowout, Rin[Ra]
  - jr 20: T3 Rout[Ra], PCin.
  - mfhi 24: T3 HIout, Rin[Ra]. mflo 25: T3 LOout, Rin[Ra].
  - nop 26: no execute step.
  - halt 27: go to HALT. HALT holds until clear.
  - Any other opcode: illegal=1 in T3, then treated as nop.
- Instruction end: go to T0 if run=1, else IDLE.
- Latency with zero-wait memory (mem_ready high on first request cycle):
  - fetch 3 cycles
  - R-type/imm 6 total; ld/st 8; mul/div 7; neg/not 5; jr/mf/nop 4
- Memory wait:
  - Timeout counter resets on entering T1/T6(ld)/T7(st) and increments each waiting cycle.
  - Reaching MEM_TIMEOUT without mem_ready → FAULT (fault=1, all enables 0, held until clear).
  - mem_ready outside a wait state is ignored.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (values above)
  - state enum (4-bit)
  - IR field bit positions
- Natural sub-module: ir_decode. Combinational; maps ir[31:27] to an instruction class (ALU_R, ALU_I, LD, LDI, ST, MULDIV, UNARY, JR, MFHI, MFLO, NOP, HALT, ILLEGAL) and the ALU opcode. The FSM stays in control_sequencer.

Test Plan:
1. clear low, then run=1, ir=0x1A920000 (add R5,R2,R4), mem_ready=1 → T3: Rout=0x0004, Yin; T4: Rout=0x0010, opcode=3, Zin; T5: Rin=0x0020, Zlowout; back to T0 on cycle 7.
2. ld R1,0x10(R2), ir=0x00900010, mem_ready delayed 2 cycles in T6 → Read high 3 cycles, MDRin exactly 1 cycle, T7 Rin=0x0002 with MDRout.
3. mul R3,R1, ir=0x79880000 → T4 opcode=15; T5 LOin+Zlowout; T6 HIin+Zhighout; Rin stays 0.
4. ir=0xF8000000 (opcode 31) → illegal pulses one cycle in T3, next fetch begins; ir=0xD8000000 → halted=1 and holds for 100 cycles despite run=1.
5. MEM_TIMEOUT=4, mem_ready held 0 in T1 → fault=1 after 4 wait cycles, all enables 0.
6. clear asserted during T4 of an add → outputs 0 immediately; after release and run=1, T0 asserts PCout, MARin, IncPC, Zin.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-bus CPU control path: opcodes, IR field
// positions, sequencer states and the decoded instruction classes.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHRA = 5'd8;
  localparam logic [4:0] OP_SHL  = 5'd9;
  localparam logic [4:0] OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LD, C_LDI, C_ST, C_MULDIV, C_UNARY,
    C_JR, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILLEGAL
  } iclass_e;

  function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/ir_decode.sv
// Maps the IR opcode field to an instruction class and the ALU operation
// used during that instruction's arithmetic step.
module ir_decode
  import cpu_pkg::*;
(
  input  logic [4:0] op,
  output iclass_e    iclass,
  output logic [4:0] alu_op
);

  always_comb begin
    iclass = C_ILLEGAL;
    alu_op = 5'd0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
        iclass = C_ALU_R;
        alu_op = op;
      end
      OP_ADDI: begin iclass = C_ALU_I; alu_op = OP_ADD; end
      OP_ANDI: begin iclass = C_ALU_I; alu_op = OP_AND; end
      OP_ORI:  begin iclass = C_ALU_I; alu_op = OP_OR;  end
      // address and ldi arithmetic is always Rb + C
      OP_LD:   begin iclass = C_LD;  alu_op = OP_ADD; end
      OP_LDI:  begin iclass = C_LDI; alu_op = OP_ADD; end
      OP_ST:   begin iclass = C_ST;  alu_op = OP_ADD; end
      OP_MUL, OP_DIV: begin iclass = C_MULDIV; alu_op = op; end
      OP_NEG, OP_NOT: begin iclass = C_UNARY;  alu_op = op; end
      OP_JR:   iclass = C_JR;
      OP_MFHI: iclass = C_MFHI;
      OP_MFLO: iclass = C_MFLO;
      OP_NOP:  iclass = C_NOP;
      OP_HALT: iclass = C_HALT;
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: steps the single-bus datapath through fetch
// (T0-T2) and class-specific execute steps (T3-T7), with a memory wait timeout.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin,
  output logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout,
  output logic        IncPC, Read, Write,
  output logic [4:0]  opcode,
  output logic        halted,
  output logic        fault,
  output logic        illegal,
  output logic [3:0]  state_out
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  iclass_e    iclass;
  logic [4:0] alu_op;
  logic       mem_waiting;
  state_e     end_state;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  logic       unused_ir;

  ir_decode u_ir_decode (
    .op     (ir[OP_MSB:OP_LSB]),
    .iclass (iclass),
    .alu_op (alu_op)
  );

  assign ra_oh     = reg_onehot(ir[RA_MSB:RA_LSB]);
  assign rb_oh     = reg_onehot(ir[RB_MSB:RB_LSB]);
  assign rc_oh     = reg_onehot(ir[RC_MSB:RC_LSB]);
  assign unused_ir = ^ir[RC_LSB-1:0];
  assign state_out = state_q;
  assign end_state = run ? S_T0 : S_IDLE;

  assign mem_waiting = (state_q == S_T1) ||
                       (state_q == S_T6 && iclass == C_LD) ||
                       (state_q == S_T7 && iclass == C_ST);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // The wait counter only survives while stalled in a memory wait, so it is
  // automatically zero on entry to each wait state.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 8'd0;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        case (iclass)
          C_ALU_R, C_ALU_I, C_LD, C_LDI, C_ST, C_MULDIV, C_UNARY: state_d = S_T4;
          C_HALT:  state_d = S_HALT;
          default: state_d = end_state;
        endcase
      end
      S_T4: state_d = (iclass == C_UNARY) ? end_state : S_T5;
      S_T5: state_d = (iclass == C_LD || iclass == C_ST || iclass == C_MULDIV) ? S_T6 : end_state;
      S_T6: begin
        if (iclass == C_ST || (iclass == C_LD && mem_ready)) state_d = S_T7;
        else if (iclass != C_LD) state_d = end_state;
      end
      S_T7: if (iclass != C_ST || mem_ready) state_d = end_state;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (mem_waiting && !mem_ready) begin
      if (wait_cnt_q == TIMEOUT_LAST) state_d = S_FAULT;
      else wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_comb begin
    Rin = 16'h0000; Rout = 16'h0000;
    HIin = 1'b0; LOin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    PCout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    opcode = 5'd0; halted = 1'b0; fault = 1'b0; illegal = 1'b0;
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = mem_ready; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (iclass)
          C_ALU_R, C_ALU_I, C_LD, C_LDI, C_ST: begin Rout = rb_oh; Yin = 1'b1; end
          C_MULDIV: begin Rout = ra_oh; Yin = 1'b1; end
          C_UNARY:  begin Rout = rb_oh; opcode = alu_op; Zin = 1'b1; end
          C_JR:     begin Rout = ra_oh; PCin = 1'b1; end
          C_MFHI:   begin HIout = 1'b1; Rin = ra_oh; end
          C_MFLO:   begin LOout = 1'b1; Rin = ra_oh; end
          C_ILLEGAL: illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        case (iclass)
          C_ALU_R:  begin Rout = rc_oh; opcode = alu_op; Zin = 1'b1; end
          C_ALU_I, C_LD, C_LDI, C_ST: begin Cout = 1'b1; opcode = alu_op; Zin = 1'b1; end
          C_MULDIV: begin Rout = rb_oh; opcode = alu_op; Zin = 1'b1; end
          C_UNARY:  begin Zlowout = 1'b1; Rin = ra_oh; end
          default: ;
        endcase
      end
      S_T5: begin
        case (iclass)
          C_ALU_R, C_ALU_I, C_LDI: begin Zlowout = 1'b1; Rin = ra_oh; end
          C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          C_MULDIV:   begin Zlowout = 1'b1; LOin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (iclass)
          C_LD:     begin Read = 1'b1; MDRin = mem_ready; end
          C_ST:     begin Rout = ra_oh; MDRin = 1'b1; end
          C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        case (iclass)
          C_LD: begin MDRout = 1'b1; Rin = ra_oh; end
          C_ST: Write = 1'b1;
          default: ;
        endcase
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: fetch, R-type, ld, st,
// mul, illegal, halt, memory timeout and asynchronous clear.
module tb_control_sequencer;

  localparam logic [31:0] IR_ADD  = 32'h1A92_0000;
  localparam logic [31:0] IR_LD   = 32'h0090_0010;
  localparam logic [31:0] IR_ST   = 32'h1180_0000;
  localparam logic [31:0] IR_MUL  = 32'h7988_0000;
  localparam logic [31:0] IR_ILL  = 32'hF800_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3,
                         ST_T3 = 4'd4, ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7,
                         ST_T7 = 4'd8, ST_HALT = 4'd9, ST_FAULT = 4'd10;

  localparam logic [17:0] K_HIin = 18'h20000, K_LOin = 18'h10000, K_Yin = 18'h08000,
                          K_Zin = 18'h04000, K_PCin = 18'h02000, K_IRin = 18'h01000,
                          K_MARin = 18'h00800, K_MDRin = 18'h00400, K_HIout = 18'h00200,
                          K_LOout = 18'h00100, K_Zhighout = 18'h00080, K_Zlowout = 18'h00040,
                          K_PCout = 18'h00020, K_MDRout = 18'h00010, K_Cout = 18'h00008,
                          K_IncPC = 18'h00004, K_Read = 18'h00002, K_Write = 18'h00001;
  localparam logic [17:0] K_FETCH0 = K_PCout | K_MARin | K_IncPC | K_Zin;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;
  logic [15:0] Rin, Rout;
  logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin;
  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout;
  logic        IncPC, Read, Write;
  logic [4:0]  opcode;
  logic        halted, fault, illegal;
  logic [3:0]  state_out;
  logic [17:0] ctrl_vec;

  int checks = 0;
  int errors = 0;
  int bus_conflicts = 0;
  int read_cycles, mdrin_cycles, halt_cycles, wait_cycles;

  control_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
    .Rin(Rin), .Rout(Rout),
    .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .Cout(Cout),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .opcode(opcode), .halted(halted), .fault(fault), .illegal(illegal),
    .state_out(state_out)
  );

  always #5 clock = ~clock;

  assign ctrl_vec = {HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin,
                     HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout,
                     IncPC, Read, Write};

  // Count any cycle where more than one source drives the shared bus.
  always @(negedge clock) begin
    if ($countones({Rout, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Cout}) > 1)
      bus_conflicts++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkStep(input string tag, input logic [3:0] exp_state,
                           input logic [17:0] exp_ctrl, input logic [15:0] exp_rin,
                           input logic [15:0] exp_rout);
    checkOutput({tag, ".state"}, 32'(state_out), 32'(exp_state));
    checkOutput({tag, ".ctrl"},  32'(ctrl_vec),  32'(exp_ctrl));
    checkOutput({tag, ".Rin"},   32'(Rin),       32'(exp_rin));
    checkOutput({tag, ".Rout"},  32'(Rout),      32'(exp_rout));
  endtask

  task automatic applyStimulus(input logic c, input logic r, input logic [31:0] i,
                               input logic m);
    clear = c; run = r; ir = i; mem_ready = m;
    #1;
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clear = 1'b0; run = 1'b0; ir = 32'h0; mem_ready = 1'b0;
    #12;
    checkStep("reset", ST_IDLE, 18'h0, 16'h0, 16'h0);
    checkOutput("reset.flags", 32'({halted, fault, illegal, opcode}), 32'h0);

    // add R5,R2,R4 with zero-wait memory
    tick(); applyStimulus(1'b1, 1'b1, IR_ADD, 1'b1);
    checkStep("release", ST_IDLE, 18'h0, 16'h0, 16'h0);
    tick(); checkStep("add.T0", ST_T0, K_FETCH0, 16'h0, 16'h0);
    tick(); checkStep("add.T1", ST_T1, K_Zlowout | K_PCin | K_Read | K_MDRin, 16'h0, 16'h0);
    tick(); checkStep("add.T2", ST_T2, K_MDRout | K_IRin, 16'h0, 16'h0);
    tick(); checkStep("add.T3", ST_T3, K_Yin, 16'h0, 16'h0004);
    tick(); checkStep("add.T4", ST_T4, K_Zin, 16'h0, 16'h0010);
    checkOutput("add.T4.opcode", 32'(opcode), 32'd3);
    tick(); checkStep("add.T5", ST_T5, K_Zlowout, 16'h0020, 16'h0);
    tick(); checkStep("add.next", ST_T0, K_FETCH0, 16'h0, 16'h0);

    // ld R1,0x10(R2) with two wait cycles in T6
    applyStimulus(1'b1, 1'b1, IR_LD, 1'b1);
    tick(); tick();
    tick(); checkStep("ld.T3", ST_T3, K_Yin, 16'h0, 16'h0004);
    tick(); checkStep("ld.T4", ST_T4, K_Cout | K_Zin, 16'h0, 16'h0);
    checkOutput("ld.T4.opcode", 32'(opcode), 32'd3);
    tick(); checkStep("ld.T5", ST_T5, K_Zlowout | K_MARin, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b1, IR_LD, 1'b0);
    read_cycles = 0; mdrin_cycles = 0;
    for (int i = 0; i < 2; i++) begin
      tick(); checkStep("ld.T6wait", ST_T6, K_Read, 16'h0, 16'h0);
      read_cycles += int'(Read); mdrin_cycles += int'(MDRin);
    end
    applyStimulus(1'b1, 1'b0, IR_LD, 1'b1);
    checkStep("ld.T6ready", ST_T6, K_Read | K_MDRin, 16'h0, 16'h0);
    read_cycles += int'(Read); mdrin_cycles += int'(MDRin);
    tick(); checkStep("ld.T7", ST_T7, K_MDRout, 16'h0002, 16'h0);
    read_cycles += int'(Read); mdrin_cycles += int'(MDRin);
    checkOutput("ld.read_cycles", 32'(read_cycles), 32'd3);
    checkOutput("ld.mdrin_cycles", 32'(mdrin_cycles), 32'd1);
    tick(); checkStep("ld.idle", ST_IDLE, 18'h0, 16'h0, 16'h0);

    // mul R3,R1
    applyStimulus(1'b1, 1'b1, IR_MUL, 1'b1);
    tick(); tick(); tick();
    tick(); checkStep("mul.T3", ST_T3, K_Yin, 16'h0, 16'h0008);
    tick(); checkStep("mul.T4", ST_T4, K_Zin, 16'h0, 16'h0002);
    checkOutput("mul.T4.opcode", 32'(opcode), 32'd15);
    tick(); checkStep("mul.T5", ST_T5, K_Zlowout | K_LOin, 16'h0, 16'h0);
    tick(); checkStep("mul.T6", ST_T6, K_Zhighout | K_HIin, 16'h0, 16'h0);
    tick(); checkStep("mul.next", ST_T0, K_FETCH0, 16'h0, 16'h0);

    // undefined opcode 31, then halt
    applyStimulus(1'b1, 1'b1, IR_ILL, 1'b1);
    tick(); tick();
    tick(); checkStep("ill.T3", ST_T3, 18'h0, 16'h0, 16'h0);
    checkOutput("ill.T3.illegal", 32'(illegal), 32'd1);
    tick(); checkStep("ill.next", ST_T0, K_FETCH0, 16'h0, 16'h0);
    checkOutput("ill.next.illegal", 32'(illegal), 32'd0);
    applyStimulus(1'b1, 1'b1, IR_HALT, 1'b1);
    tick(); tick(); tick();
    tick(); checkStep("halt", ST_HALT, 18'h0, 16'h0, 16'h0);
    halt_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (halted && state_out == ST_HALT) halt_cycles++;
    end
    checkOutput("halt.held_cycles", 32'(halt_cycles), 32'd100);

    // memory timeout during fetch
    applyStimulus(1'b0, 1'b1, IR_NOP, 1'b0);
    checkStep("halt.clear", ST_IDLE, 18'h0, 16'h0, 16'h0);
    checkOutput("halt.clear.halted", 32'(halted), 32'd0);
    tick(); applyStimulus(1'b1, 1'b1, IR_NOP, 1'b0);
    tick(); checkStep("to.T0", ST_T0, K_FETCH0, 16'h0, 16'h0);
    wait_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (state_out == ST_T1 && ctrl_vec == (K_Zlowout | K_PCin | K_Read)) wait_cycles++;
    end
    checkOutput("to.wait_cycles", 32'(wait_cycles), 32'd4);
    tick(); checkStep("to.fault", ST_FAULT, 18'h0, 16'h0, 16'h0);
    checkOutput("to.fault.flag", 32'(fault), 32'd1);
    applyStimulus(1'b1, 1'b1, IR_NOP, 1'b1);
    tick(); checkStep("to.fault_held", ST_FAULT, 18'h0, 16'h0, 16'h0);

    // asynchronous clear in T4 of an add
    applyStimulus(1'b0, 1'b1, IR_ADD, 1'b1);
    tick(); applyStimulus(1'b1, 1'b1, IR_ADD, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    checkStep("clr.T4", ST_T4, K_Zin, 16'h0, 16'h0010);
    applyStimulus(1'b0, 1'b1, IR_ADD, 1'b1);
    checkStep("clr.mid", ST_IDLE, 18'h0, 16'h0, 16'h0);
    checkOutput("clr.mid.opcode", 32'(opcode), 32'd0);
    tick(); applyStimulus(1'b1, 1'b1, IR_ADD, 1'b1);
    tick(); checkStep("clr.restart", ST_T0, K_FETCH0, 16'h0, 16'h0);

    // st R3,0(R0) with one write wait cycle
    applyStimulus(1'b1, 1'b1, IR_ST, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    checkStep("st.T5", ST_T5, K_Zlowout | K_MARin, 16'h0, 16'h0);
    tick(); checkStep("st.T6", ST_T6, K_MDRin, 16'h0, 16'h0008);
    applyStimulus(1'b1, 1'b0, IR_ST, 1'b0);
    tick(); checkStep("st.T7wait", ST_T7, K_Write, 16'h0, 16'h0);
    tick(); checkStep("st.T7held", ST_T7, K_Write, 16'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, IR_ST, 1'b1);
    tick(); checkStep("st.idle", ST_IDLE, 18'h0, 16'h0, 16'h0);

    checkOutput("bus_single_driver", 32'(bus_conflicts), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
